// File: rtl/mesm6_timer.sv
// MESM-6 down-counting timer: 48-bit COUNT/LOAD, 16-bit prescaler, expiry flag and level irq.
// Simple two-state bus handshake with a registered one-cycle done pulse.
`timescale 1ns/1ps
module mesm6_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] addr,
  input  logic        read,
  input  logic        write,
  input  logic [47:0] wdata,
  output logic [47:0] rdata,
  output logic        done,
  output logic        irq
);

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  localparam logic [2:0] AddrCtrl   = 3'd0;
  localparam logic [2:0] AddrLoad   = 3'd1;
  localparam logic [2:0] AddrCount  = 3'd2;
  localparam logic [2:0] AddrStatus = 3'd3;
  localparam logic [2:0] AddrPresc  = 3'd4;

  state_e      state_q;
  logic        en_q, reload_q, ie_q, exp_q;
  logic [47:0] load_q, count_q;
  logic [15:0] presc_q, pcnt_q;

  logic        en_d, exp_d;
  logic [47:0] count_d;
  logic [15:0] pcnt_d;
  logic [47:0] rd_mux;

  logic        accept, wr_any;
  logic        wr_ctrl, wr_load, wr_count, wr_status, wr_presc;
  logic        tick, expire;
  logic        unused_addr;

  assign unused_addr = ^addr[14:3];

  // A request is only taken from IDLE; anything still held during ACK is ignored.
  assign accept    = (state_q == StIdle) && (read || write);
  assign wr_any    = accept && write;
  assign wr_ctrl   = wr_any && (addr[2:0] == AddrCtrl);
  assign wr_load   = wr_any && (addr[2:0] == AddrLoad);
  assign wr_count  = wr_any && (addr[2:0] == AddrCount);
  assign wr_status = wr_any && (addr[2:0] == AddrStatus);
  assign wr_presc  = wr_any && (addr[2:0] == AddrPresc);

  assign tick   = en_q && (pcnt_q == 16'd0);
  assign expire = tick && (count_q == 48'd0);

  assign irq = exp_q & ie_q;

  always_comb begin
    rd_mux = 48'd0;
    case (addr[2:0])
      AddrCtrl:   rd_mux = {45'd0, ie_q, reload_q, en_q};
      AddrLoad:   rd_mux = load_q;
      AddrCount:  rd_mux = count_q;
      AddrStatus: rd_mux = {47'd0, exp_q};
      AddrPresc:  rd_mux = {32'd0, presc_q};
      default:    rd_mux = 48'd0;
    endcase
  end

  // Prescaler restarts from PRESC whenever the timer is switched on.
  always_comb begin
    pcnt_d = pcnt_q;
    if (wr_ctrl && wdata[0] && !en_q) begin
      pcnt_d = presc_q;
    end else if (en_q) begin
      pcnt_d = (pcnt_q == 16'd0) ? presc_q : pcnt_q - 16'd1;
    end
  end

  // CPU writes are applied last so they take precedence over timer activity.
  always_comb begin
    count_d = count_q;
    en_d    = en_q;
    exp_d   = exp_q;
    if (tick) begin
      if (count_q != 48'd0) begin
        count_d = count_q - 48'd1;
      end else if (reload_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end
    if (wr_status && wdata[0]) begin
      exp_d = 1'b0;
    end
    if (expire) begin
      exp_d = 1'b1;
    end
    if (wr_count) begin
      count_d = wdata;
    end
    if (wr_ctrl) begin
      en_d = wdata[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      done    <= 1'b0;
      rdata   <= 48'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (read || write) begin
            state_q <= StAck;
            done    <= 1'b1;
            rdata   <= rd_mux;
          end
        end
        StAck: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      exp_q    <= 1'b0;
      load_q   <= 48'd0;
      count_q  <= 48'd0;
      presc_q  <= 16'd0;
      pcnt_q   <= 16'd0;
    end else begin
      en_q    <= en_d;
      exp_q   <= exp_d;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      if (wr_ctrl) begin
        reload_q <= wdata[1];
        ie_q     <= wdata[2];
      end
      if (wr_load) begin
        load_q <= wdata;
      end
      if (wr_presc) begin
        presc_q <= wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_mesm6_timer.sv
// Bench for mesm6_timer: directed scenarios with fixed expected values, then random bus traffic
// checked every cycle against a register-level behavioural model.
`timescale 1ns/1ps
module tb_mesm6_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] addr;
  logic        read, write;
  logic [47:0] wdata, rdata;
  logic        done, irq;

  int n_checks = 0;
  int n_errors = 0;

  // Model: architectural registers plus "bus is acknowledging" flag and last read value.
  bit          m_ack;
  logic [47:0] m_rdata;
  bit          m_en, m_reload, m_ie, m_exp;
  logic [47:0] m_load, m_count;
  logic [15:0] m_presc, m_pcnt;

  logic [47:0] v;

  mesm6_timer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .read    (read),
    .write   (write),
    .wdata   (wdata),
    .rdata   (rdata),
    .done    (done),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_ack = 0; m_rdata = '0;
    m_en = 0; m_reload = 0; m_ie = 0; m_exp = 0;
    m_load = '0; m_count = '0; m_presc = '0; m_pcnt = '0;
  endtask

  function automatic logic [47:0] reg_value(input logic [2:0] a);
    case (a)
      3'd0:    return {45'd0, m_ie, m_reload, m_en};
      3'd1:    return m_load;
      3'd2:    return m_count;
      3'd3:    return {47'd0, m_exp};
      3'd4:    return {32'd0, m_presc};
      default: return 48'd0;
    endcase
  endfunction

  // One rising edge of the specified behaviour: timer rules first, CPU writes override.
  task automatic model_step();
    bit acc, wr, tick, expire;
    logic [2:0] a;
    a      = addr[2:0];
    acc    = !m_ack && (read || write);
    wr     = acc && write;
    tick   = m_en && (m_pcnt == 16'd0);
    expire = tick && (m_count == 48'd0);
    if (acc) m_rdata = reg_value(a);
    m_ack = acc;
    if (wr && a == 3'd0 && wdata[0] && !m_en) m_pcnt = m_presc;
    else if (m_en) m_pcnt = (m_pcnt == 16'd0) ? m_presc : m_pcnt - 16'd1;
    if (tick) begin
      if (m_count != 48'd0) m_count = m_count - 48'd1;
      else if (m_reload)    m_count = m_load;
      else                  m_en = 0;
    end
    if (wr && a == 3'd3 && wdata[0]) m_exp = 0;
    if (expire) m_exp = 1;
    if (wr) begin
      case (a)
        3'd0: {m_ie, m_reload, m_en} = wdata[2:0];
        3'd1: m_load = wdata;
        3'd2: m_count = wdata;
        3'd4: m_presc = wdata[15:0];
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("done", {47'd0, done}, {47'd0, m_ack});
    check_eq("irq", {47'd0, irq}, {47'd0, m_exp & m_ie});
    if (m_ack) check_eq("rdata", rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [47:0] d);
    addr = {12'd0, a}; wdata = d; write = 1'b1;
    cycle();
    write = 1'b0;
    cycle();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [47:0] d);
    addr = {12'd0, a}; read = 1'b1;
    cycle();
    d = rdata;
    read = 1'b0;
    cycle();
  endtask

  task automatic quiesce();
    bus_write(3'd0, 48'd0);
    bus_write(3'd3, 48'd1);
  endtask

  initial begin
    reset_n = 1'b1; read = 0; write = 0; addr = '0; wdata = '0;
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    check_eq("rst_done", {47'd0, done}, 48'd0);
    check_eq("rst_rdata", rdata, 48'd0);
    check_eq("rst_irq", {47'd0, irq}, 48'd0);
    #9 reset_n = 1'b1; read = 1'b1; addr = 15'd0;
    cycle();
    check_eq("first_acc_done", {47'd0, done}, 48'd1);
    check_eq("first_acc_ctrl", rdata, 48'd0);
    read = 1'b0;
    cycle();

    // Reload mode, PRESC=0: tick every cycle
    bus_write(3'd1, 48'd5);
    bus_write(3'd2, 48'd3);
    bus_write(3'd4, 48'd0);
    bus_write(3'd0, 48'd7);
    bus_read(3'd2, v); check_eq("rl_count2", v, 48'd2);
    bus_read(3'd2, v); check_eq("rl_count0", v, 48'd0);
    bus_read(3'd2, v); check_eq("rl_reloaded", v, 48'd4);
    bus_read(3'd3, v); check_eq("rl_exp", v, 48'd1);
    check_eq("rl_irq", {47'd0, irq}, 48'd1);
    quiesce();

    // One-shot with PRESC=3: tick every 4 cycles, expiry 12 cycles after enable
    bus_write(3'd4, 48'd3);
    bus_write(3'd2, 48'd2);
    bus_write(3'd0, 48'd1);
    idle(2);
    bus_read(3'd2, v); check_eq("os_count2", v, 48'd2);
    bus_read(3'd2, v); check_eq("os_count1", v, 48'd1);
    idle(4);
    bus_read(3'd3, v); check_eq("os_exp_pre", v, 48'd0);
    bus_read(3'd3, v); check_eq("os_exp", v, 48'd1);
    check_eq("os_irq_masked", {47'd0, irq}, 48'd0);
    bus_read(3'd0, v); check_eq("os_ctrl", v, 48'd0);
    bus_read(3'd2, v); check_eq("os_count_end", v, 48'd0);

    // Unused addresses/bits and held read
    bus_write(3'd6, 48'hFFFF_FFFF_FFFF);
    bus_read(3'd6, v); check_eq("unused6", v, 48'd0);
    bus_read(3'd7, v); check_eq("unused7", v, 48'd0);
    bus_write(3'd0, 48'hFFFF_FFFF_FFF8);
    bus_read(3'd0, v); check_eq("ctrl_hibits", v, 48'd0);
    addr = 15'd5; read = 1'b1;
    cycle(); check_eq("hold_d1", {47'd0, done}, 48'd1);
    cycle(); check_eq("hold_d2", {47'd0, done}, 48'd0);
    cycle(); check_eq("hold_d3", {47'd0, done}, 48'd1);
    check_eq("hold_rdata", rdata, 48'd0);
    read = 1'b0;
    cycle(); check_eq("hold_d4", {47'd0, done}, 48'd0);

    // STATUS clear coincident with expiry, then one access later
    quiesce();
    bus_write(3'd1, 48'd100);
    bus_write(3'd4, 48'd0);
    bus_write(3'd2, 48'd1);
    bus_write(3'd0, 48'd7);
    bus_write(3'd3, 48'd1);
    bus_read(3'd3, v); check_eq("clr_race_exp", v, 48'd1);
    check_eq("clr_race_irq", {47'd0, irq}, 48'd1);
    bus_write(3'd3, 48'd1);
    bus_read(3'd3, v); check_eq("clr_exp", v, 48'd0);
    check_eq("clr_irq", {47'd0, irq}, 48'd0);

    // COUNT write on a tick edge wins
    quiesce();
    bus_write(3'd4, 48'd3);
    bus_write(3'd2, 48'd5);
    bus_write(3'd0, 48'd1);
    idle(2);
    bus_write(3'd2, 48'h100);
    bus_read(3'd2, v); check_eq("cnt_write_wins", v, 48'h100);

    // Reset pulse during ACK with the counter running
    quiesce();
    bus_write(3'd4, 48'd0);
    bus_write(3'd1, 48'd1000);
    bus_write(3'd2, 48'd0);
    bus_write(3'd0, 48'd7);
    idle(1);
    check_eq("pre_rst_irq", {47'd0, irq}, 48'd1);
    addr = 15'd2; read = 1'b1;
    @(posedge clk);
    model_step();
    #2 reset_n = 1'b0; read = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_done", {47'd0, done}, 48'd0);
    check_eq("mid_rst_rdata", rdata, 48'd0);
    check_eq("mid_rst_irq", {47'd0, irq}, 48'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_nodone", {47'd0, done}, 48'd0);
    for (int a = 0; a < 5; a++) begin
      bus_read(3'(a), v);
      check_eq("post_rst_reg", v, 48'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      read  = (r <= 2) || (r == 6);
      write = (r >= 3 && r <= 6);
      addr  = {12'($urandom), 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 7) == 0) wdata = {16'($urandom), 32'($urandom)};
      else                           wdata = 48'($urandom_range(0, 12));
      cycle();
    end
    read = 0; write = 0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mesm6_timer.md
MESM6_TIMER -- requirements
Module: mesm6_timer

Interface
REQ-001 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 Port: addr  input  15  register address from bus controller; only addr[2:0] decoded (selects one of 8 word registers).
REQ-004 Port: read  input  1  read request, already chip-selected by bus controller; held until done.
REQ-005 Port: write  input  1  write request, already chip-selected; held until done.
REQ-006 Port: wdata  input  48  write data word.
REQ-007 Port: rdata  output  48  read data word, registered, valid while done=1.
REQ-008 Port: done  output  1  operation complete, one-cycle pulse.
REQ-009 Port: irq  output  1  interrupt request to PIC, level.
REQ-010 Register map (addr[2:0]): 0 CTRL (bit0 EN, bit1 RELOAD, bit2 IE), 1 LOAD[47:0], 2 COUNT[47:0], 3 STATUS (bit0 EXP), 4 PRESC[15:0]; 5-7 unused.

Function
REQ-011 Bus FSM SHALL have two states: IDLE, ACK.
REQ-012 IDLE->ACK when read|write sampled high; ACK->IDLE unconditionally next cycle.
REQ-013 done SHALL equal 1 exactly while in ACK (one cycle, latency 1 clock after request sampled).
REQ-014 Request still high in ACK SHALL be ignored; request high again in the following IDLE SHALL start a new access.
REQ-015 read and write both high: write SHALL take effect and rdata SHALL return the pre-write register value.
REQ-016 Write SHALL update the register on the IDLE->ACK edge; rdata SHALL be captured on the same edge.
REQ-017 Reads of unused addresses and unused bits SHALL return 0; writes to them SHALL be ignored; they still complete with done.
REQ-018 Write to STATUS with wdata[0]=1 SHALL clear EXP; wdata[0]=0 SHALL leave EXP unchanged.
REQ-019 Prescaler: 16-bit down-counter PCNT; while EN=1, PCNT=0 produces tick and reloads PRESC, else PCNT decrements; PRESC=0 SHALL give a tick every cycle.
REQ-020 EN=0 SHALL freeze COUNT and hold PCNT; write of EN 0->1 SHALL load PCNT from PRESC.
REQ-021 On tick with COUNT!=0: COUNT decrements by 1 (48-bit, no wrap).
REQ-022 On tick with COUNT=0: EXP set; if RELOAD=1 COUNT<=LOAD; if RELOAD=0 EN cleared and COUNT stays 0.
REQ-023 irq SHALL equal EXP & IE, combinationally from registered bits.
REQ-024 Simultaneous CPU write to COUNT and tick: CPU write SHALL win.
REQ-025 Simultaneous STATUS clear and expiry: set SHALL win (EXP=1).
REQ-026 Simultaneous CPU write to CTRL and expiry with RELOAD=0: CPU-written EN SHALL win.
REQ-027 LOAD write SHALL NOT alter COUNT.

Reset
REQ-028 reset_n low SHALL immediately force: FSM IDLE, done=0, rdata=0, irq=0, CTRL=0, LOAD=0, COUNT=0, EXP=0, PRESC=0, PCNT=0.
REQ-029 Reset asserted mid-access SHALL abort it; no done pulse SHALL follow for that access after release.
REQ-030 First access SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-031 Write LOAD=5, COUNT=3, PRESC=0, CTRL=0b111 -> COUNT reads 2,1,0 on successive ticks; EXP=1 and irq=1 one tick after COUNT reaches 0; COUNT reloads to 5.
REQ-032 PRESC=3, COUNT=2, CTRL=0b001 -> COUNT decrements every 4 cycles; expiry after 12 cycles from enable; EN reads 0 afterwards, COUNT=0, irq stays 0 (IE=0) while EXP=1.
REQ-033 Read of addr 5, 6, 7 -> rdata=0, done pulses exactly one cycle after read; holding read high 3 cycles yields done at cycles 1 and 3.
REQ-034 Write STATUS=1 in same cycle as expiry -> EXP remains 1; write STATUS=1 one cycle later -> EXP=0, irq=0.
REQ-035 CPU write COUNT=0x100 in same cycle as tick -> COUNT reads 0x100, not 0xFF.
REQ-036 Drop reset_n for 1 ns during ACK with COUNT running -> all outputs 0 immediately, no done pulse after release, registers read reset values.
